// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer
//   Plays a programmable table of duty words into the PWM controller's duty
//   input. Each entry is held for hold_periods+1 PWM periods. Playback is
//   either one-shot or looped. The duty word changes only on the clock edge
//   after a period_end pulse, so a new duty always takes effect from count 0
//   of the next PWM period.
//
// Ports
//   clk, reset    : system clock, synchronous active-high reset
//   wr_en/addr/data : table write port, accepted in every state
//   seq_last      : last entry index to play, captured at start
//   hold_periods  : extra periods per entry, captured at start
//   loop_en       : restart at entry 0 after seq_last, captured at start
//   start, stop   : one-cycle control requests
//   period_end    : one-cycle pulse on the last count of each PWM period
//   duty_out      : registered duty word to the PWM controller
//   entry_idx     : table index currently driving duty_out
//   busy          : sequencer armed or running
//   done          : sticky, set when a one-shot sequence completes
module pwm_duty_sequencer #(
   parameter int DW = 8,
   parameter int AW = 4,
   parameter int HW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] seq_last,
   input  logic [HW-1:0] hold_periods,
   input  logic          loop_en,
   input  logic          start,
   input  logic          stop,
   input  logic          period_end,
   output logic [DW-1:0] duty_out,
   output logic [AW-1:0] entry_idx,
   output logic          busy,
   output logic          done
);

   localparam int DEPTH = 2**AW;

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] duty_q, duty_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          done_q, done_d;
   logic          stop_pend_q, stop_pend_d;
   logic [AW-1:0] sh_last_q, sh_last_d;
   logic [HW-1:0] sh_hold_q, sh_hold_d;
   logic          sh_loop_q, sh_loop_d;
   logic [DW-1:0] table_q [DEPTH];
   logic [DW-1:0] table_d [DEPTH];

   logic [AW-1:0] idx_inc;
   logic          stop_req;

   assign idx_inc  = idx_q + 1'b1;
   // A stop seen earlier in the period or in this very cycle both count.
   assign stop_req = stop | stop_pend_q;

   always_comb begin
      state_d     = state_q;
      duty_d      = duty_q;
      idx_d       = idx_q;
      hold_d      = hold_q;
      done_d      = done_q;
      stop_pend_d = stop_pend_q;
      sh_last_d   = sh_last_q;
      sh_hold_d   = sh_hold_q;
      sh_loop_d   = sh_loop_q;
      table_d     = table_q;

      if (wr_en) begin
         table_d[wr_addr] = wr_data;
      end

      case (state_q)
         IDLE, DONE: begin
            // period_end in the start cycle is deliberately not consumed.
            if (start) begin
               sh_last_d = seq_last;
               sh_hold_d = hold_periods;
               sh_loop_d = loop_en;
               idx_d     = '0;
               done_d    = 1'b0;
               state_d   = ARM;
            end
         end

         ARM, RUN: begin
            if (period_end) begin
               if (stop_req) begin
                  // Stop outranks any load, advance or completion.
                  duty_d      = '0;
                  idx_d       = '0;
                  stop_pend_d = 1'b0;
                  state_d     = IDLE;
               end else if (state_q == ARM) begin
                  duty_d  = table_q[0];
                  idx_d   = '0;
                  hold_d  = sh_hold_q;
                  state_d = RUN;
               end else if (hold_q != '0) begin
                  hold_d = hold_q - 1'b1;
               end else if (idx_q != sh_last_q) begin
                  idx_d  = idx_inc;
                  duty_d = table_q[idx_inc];
                  hold_d = sh_hold_q;
               end else if (sh_loop_q) begin
                  idx_d  = '0;
                  duty_d = table_q[0];
                  hold_d = sh_hold_q;
               end else begin
                  duty_d  = '0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end else if (stop) begin
               stop_pend_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         duty_q      <= '0;
         idx_q       <= '0;
         hold_q      <= '0;
         done_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         sh_last_q   <= '0;
         sh_hold_q   <= '0;
         sh_loop_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
         stop_pend_q <= stop_pend_d;
         sh_last_q   <= sh_last_d;
         sh_hold_q   <= sh_hold_d;
         sh_loop_q   <= sh_loop_d;
         table_q     <= table_d;
      end
   end

   assign duty_out  = duty_q;
   assign entry_idx = idx_q;
   assign busy      = (state_q == ARM) || (state_q == RUN);
   assign done      = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, away from the edge.
module tb_pwm_duty_sequencer;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int HW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] seq_last;
   logic [HW-1:0] hold_periods;
   logic          loop_en;
   logic          start;
   logic          stop;
   logic          period_end;
   logic [DW-1:0] duty_out;
   logic [AW-1:0] entry_idx;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   pwm_duty_sequencer #(.DW(DW), .AW(AW), .HW(HW)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .seq_last     (seq_last),
      .hold_periods (hold_periods),
      .loop_en      (loop_en),
      .start        (start),
      .stop         (stop),
      .period_end   (period_end),
      .duty_out     (duty_out),
      .entry_idx    (entry_idx),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = DW'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_pe();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
   endtask

   // One full 256-clock PWM period ending with period_end.
   task automatic next_period();
      repeat (255) tick();
      pulse_pe();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int e_duty;
      int e_idx;

      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      seq_last = '0; hold_periods = '0; loop_en = 1'b0;
      start = 1'b0; stop = 1'b0; period_end = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check_eq("rst_duty", 32'(duty_out), 0);
      check_eq("rst_idx",  32'(entry_idx), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);

      // One-shot, hold 0.
      wr(0, 64); wr(1, 128); wr(2, 192);
      seq_last = 4'd2; hold_periods = 8'd0; loop_en = 1'b0;
      pulse_start();
      check_eq("arm_busy", 32'(busy), 1);
      repeat (255) tick();
      check_eq("arm_duty", 32'(duty_out), 0);
      pulse_pe();
      check_eq("os_p1", 32'(duty_out), 64);
      repeat (255) tick();
      check_eq("os_p1_hold", 32'(duty_out), 64);
      pulse_pe();
      check_eq("os_p2", 32'(duty_out), 128);
      check_eq("os_p2_idx", 32'(entry_idx), 1);
      next_period();
      check_eq("os_p3", 32'(duty_out), 192);
      check_eq("os_p3_idx", 32'(entry_idx), 2);
      next_period();
      check_eq("os_end_duty", 32'(duty_out), 0);
      check_eq("os_end_done", 32'(done), 1);
      check_eq("os_end_busy", 32'(busy), 0);

      // Looped, hold 2, with mid-run config changes and a table write.
      hold_periods = 8'd2; loop_en = 1'b1;
      pulse_start();
      check_eq("lp_done_clr", 32'(done), 0);
      for (int k = 1; k <= 13; k++) begin
         next_period();
         if (k <= 3)       begin e_duty = 64;  e_idx = 0; end
         else if (k <= 6)  begin e_duty = 128; e_idx = 1; end
         else if (k <= 9)  begin e_duty = 192; e_idx = 2; end
         else if (k <= 12) begin e_duty = 64;  e_idx = 0; end
         else              begin e_duty = 200; e_idx = 1; end
         check_eq($sformatf("lp_duty_k%0d", k), 32'(duty_out), e_duty);
         check_eq($sformatf("lp_idx_k%0d", k), 32'(entry_idx), e_idx);
         check_eq($sformatf("lp_done_k%0d", k), 32'(done), 0);
         if (k == 2) begin
            hold_periods = 8'd0; loop_en = 1'b0; seq_last = 4'd0;
         end
         if (k == 4) wr(1, 200);
         if (k == 5) pulse_start();
      end

      // Stop mid-period: duty holds until the period boundary.
      repeat (50) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      check_eq("stp_hold_duty", 32'(duty_out), 200);
      check_eq("stp_hold_busy", 32'(busy), 1);
      repeat (204) tick();
      pulse_pe();
      check_eq("stp_duty", 32'(duty_out), 0);
      check_eq("stp_idx",  32'(entry_idx), 0);
      check_eq("stp_busy", 32'(busy), 0);
      check_eq("stp_done", 32'(done), 0);

      // start with period_end in the same cycle; then stop while 128.
      wr(1, 128);
      seq_last = 4'd2; hold_periods = 8'd0; loop_en = 1'b1;
      start = 1'b1; period_end = 1'b1; tick(); start = 1'b0; period_end = 1'b0;
      check_eq("sp_busy", 32'(busy), 1);
      check_eq("sp_duty", 32'(duty_out), 0);
      next_period();
      check_eq("sp_first", 32'(duty_out), 64);
      next_period();
      check_eq("sp_second", 32'(duty_out), 128);
      repeat (100) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      repeat (154) tick();
      check_eq("stp128_hold", 32'(duty_out), 128);
      pulse_pe();
      check_eq("stp128_duty", 32'(duty_out), 0);
      check_eq("stp128_busy", 32'(busy), 0);

      // stop coincident with period_end.
      pulse_start();
      next_period();
      check_eq("co_first", 32'(duty_out), 64);
      repeat (255) tick();
      stop = 1'b1; period_end = 1'b1; tick(); stop = 1'b0; period_end = 1'b0;
      check_eq("co_duty", 32'(duty_out), 0);
      check_eq("co_busy", 32'(busy), 0);

      // Reset mid-run at entry 2.
      loop_en = 1'b0;
      pulse_start();
      next_period(); next_period(); next_period();
      check_eq("rr_pre_duty", 32'(duty_out), 192);
      check_eq("rr_pre_idx",  32'(entry_idx), 2);
      do_reset();
      check_eq("rr_duty", 32'(duty_out), 0);
      check_eq("rr_idx",  32'(entry_idx), 0);
      check_eq("rr_busy", 32'(busy), 0);
      check_eq("rr_done", 32'(done), 0);
      pulse_start();
      pulse_pe();
      check_eq("rr_tbl0", 32'(duty_out), 0);
      check_eq("rr_run_busy", 32'(busy), 1);
      do_reset();

      // Single entry held for the maximum 2**HW periods (short periods).
      wr(0, 77);
      seq_last = 4'd0; hold_periods = 8'd255; loop_en = 1'b0;
      pulse_start();
      for (int k = 1; k <= 256; k++) begin
         pulse_pe();
         tick();
         if (k == 1)   check_eq("mx_first", 32'(duty_out), 77);
      end
      check_eq("mx_last_duty", 32'(duty_out), 77);
      check_eq("mx_last_busy", 32'(busy), 1);
      pulse_pe();
      check_eq("mx_end_duty", 32'(duty_out), 0);
      check_eq("mx_end_done", 32'(done), 1);
      check_eq("mx_end_idx",  32'(entry_idx), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
